// File: rtl/unidade_controle_if.sv
// Control-unit signal bundle for the 9-bit simple processor.
// master: datapath/upstream side (drives Run, IR, Gnz; observes control lines).
// slave : unidade_controle (consumes Run, IR, Gnz; drives control lines).
interface unidade_controle_if #(
  parameter int unsigned IR_W = 9,
  parameter int unsigned NREG = 8
);
  logic            Run;
  logic [IR_W-1:0] IR;
  logic            Gnz;
  logic            IRin;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            DINout;
  logic            Gout;
  logic            Ain;
  logic            Gin;
  logic            AddSub;
  logic            Done;
  logic [1:0]      Tstep;

  modport master (
    output Run, IR, Gnz,
    input  IRin, Rout, Rin, DINout, Gout, Ain, Gin, AddSub, Done, Tstep
  );

  modport slave (
    input  Run, IR, Gnz,
    output IRin, Rout, Rin, DINout, Gout, Ain, Gin, AddSub, Done, Tstep
  );
endinterface

// File: rtl/unidade_controle.sv
// Control FSM for the 9-bit simple processor.
// Sequences each instruction (IR = III XXX YYY) over timesteps T0..T3 and
// drives IR load, bus selects, register/A/G enables and ALU mode.
// Optional feature: define MVNZ_EN to decode opcode 100 as mvnz Rx,Ry
// (conditional move on G != 0); otherwise opcode 100 is a NOP.
// Resetn is active-high and synchronous despite its name.
module unidade_controle #(
  parameter int unsigned IR_W = 9,
  parameter int unsigned NREG = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  unidade_controle_if.slave    bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  tstep_e tstep_q, tstep_d;

  logic [2:0]      opcode;
  logic [NREG-1:0] rx_oh;
  logic [NREG-1:0] ry_oh;

  assign opcode = bus.IR[IR_W-1 -: 3];
  assign rx_oh  = NREG'(1) << bus.IR[5:3];
  assign ry_oh  = NREG'(1) << bus.IR[2:0];

`ifndef MVNZ_EN
  // Gnz only matters for mvnz; keep it referenced so the port stays visible.
  logic unused_gnz;
  assign unused_gnz = bus.Gnz;
`endif

  // Timestep register; reset wins over any pending transition.
  always_ff @(posedge Clock) begin
    if (Resetn) tstep_q <= T0;
    else        tstep_q <= tstep_d;
  end

  // Next-timestep and control-line decode from (Tstep, IR, Gnz).
  always_comb begin
    tstep_d    = tstep_q;
    bus.IRin   = 1'b0;
    bus.Rout   = '0;
    bus.Rin    = '0;
    bus.DINout = 1'b0;
    bus.Gout   = 1'b0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.AddSub = 1'b0;
    bus.Done   = 1'b0;

    unique case (tstep_q)
      T0: begin
        bus.IRin = 1'b1;
        tstep_d  = bus.Run ? T1 : T0;
      end
      T1: begin
        case (opcode)
          3'b000: begin
            bus.Rout = ry_oh;
            bus.Rin  = rx_oh;
            bus.Done = 1'b1;
          end
          3'b001: begin
            bus.DINout = 1'b1;
            bus.Rin    = rx_oh;
            bus.Done   = 1'b1;
          end
          3'b010, 3'b011: begin
            bus.Rout = rx_oh;
            bus.Ain  = 1'b1;
          end
`ifdef MVNZ_EN
          3'b100: begin
            if (bus.Gnz) begin
              bus.Rout = ry_oh;
              bus.Rin  = rx_oh;
            end
            bus.Done = 1'b1;
          end
`endif
          default: bus.Done = 1'b1;
        endcase
        tstep_d = bus.Done ? T0 : T2;
      end
      // T2/T3 are only reached by add/sub.
      T2: begin
        bus.Rout   = ry_oh;
        bus.Gin    = 1'b1;
        bus.AddSub = (opcode == 3'b011);
        tstep_d    = T3;
      end
      T3: begin
        bus.Gout = 1'b1;
        bus.Rin  = rx_oh;
        bus.Done = 1'b1;
        tstep_d  = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  assign bus.Tstep = tstep_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed, table-driven bench for unidade_controle.
module tb_unidade_controle;

  logic Clock;
  logic Resetn;
  int   checks;
  int   errors;
  logic started;

  unidade_controle_if #(.IR_W(9), .NREG(8)) bus ();

  unidade_controle #(.IR_W(9), .NREG(8)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Expected-output layout: {Tstep, IRin, Rout, Rin, DINout, Gout, Ain, Gin, AddSub, Done}
  typedef struct {
    logic        rst;
    logic        run;
    logic [8:0]  ir;
    logic        gnz;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [24:0] e(input logic [1:0] ts, input logic irin,
                                    input logic [7:0] rout, input logic [7:0] rin,
                                    input logic din, input logic gout, input logic ain,
                                    input logic gin, input logic as, input logic done);
    return {ts, irin, rout, rin, din, gout, ain, gin, as, done};
  endfunction

  task automatic addv(input logic rst, input logic run, input logic [8:0] ir,
                      input logic gnz, input logic [24:0] exp);
    vec_t v;
    v.rst = rst; v.run = run; v.ir = ir; v.gnz = gnz; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [24:0] actual();
    return {bus.Tstep, bus.IRin, bus.Rout, bus.Rin, bus.DINout, bus.Gout,
            bus.Ain, bus.Gin, bus.AddSub, bus.Done};
  endfunction

  // Structural invariants: single bus driver, one-hot Rin, AddSub only in T2.
  always @(negedge Clock) begin
    #2;
    if (started) begin
      checks++;
      if (($countones(bus.Rout) + int'(bus.DINout) + int'(bus.Gout)) > 1 ||
          $countones(bus.Rin) > 1 || (bus.AddSub && bus.Tstep != 2'd2)) begin
        errors++;
        $display("FAIL invariant: Rout=%h DINout=%b Gout=%b Rin=%h AddSub=%b Tstep=%0d, required single driver/one-hot Rin/AddSub only in T2",
                 bus.Rout, bus.DINout, bus.Gout, bus.Rin, bus.AddSub, bus.Tstep);
      end
    end
  end

  localparam logic [8:0] MVI_R0    = 9'b001_000_000;
  localparam logic [8:0] MV_R1_R0  = 9'b000_001_000;
  localparam logic [8:0] SUB_R2_R3 = 9'b011_010_011;
  localparam logic [8:0] ADD_R3_R1 = 9'b010_011_001;
  localparam logic [8:0] MV_R3_R3  = 9'b000_011_011;
  localparam logic [8:0] ADD_R2_R2 = 9'b010_010_010;
  localparam logic [8:0] NOP_111   = 9'b111_101_110;
  localparam logic [8:0] MVNZ      = 9'b100_100_101;
  localparam logic [8:0] ADD_R1_R2 = 9'b010_001_010;
  localparam logic [8:0] ADD_R1_R1 = 9'b010_001_001;

  int lat;

  initial begin
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    Resetn  = 1'b1;
    bus.Run = 1'b0;
    bus.IR  = '0;
    bus.Gnz = 1'b0;

    // rst run ir gnz | Tstep IRin Rout Rin DIN Gout Ain Gin AS Done
    addv(1, 0, '0,        0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 0 reset state
    addv(0, 0, MVI_R0,    0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 1 idle, Run=0
    addv(0, 1, MVI_R0,    0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 2 mvi T0
    addv(0, 0, MVI_R0,    0, e(1, 0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 1)); // 3 mvi T1
    addv(0, 1, MV_R1_R0,  0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 4 mv T0
    addv(0, 1, MV_R1_R0,  0, e(1, 0, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1)); // 5 mv T1, Run ignored
    addv(0, 1, SUB_R2_R3, 0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 6 sub T0
    addv(0, 0, SUB_R2_R3, 0, e(1, 0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0)); // 7 sub T1
    addv(0, 0, SUB_R2_R3, 0, e(2, 0, 8'h08, 8'h00, 0, 0, 0, 1, 1, 0)); // 8 sub T2
    addv(0, 0, SUB_R2_R3, 0, e(3, 0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 1)); // 9 sub T3
    addv(0, 1, ADD_R3_R1, 0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 10 add T0
    addv(0, 0, ADD_R3_R1, 0, e(1, 0, 8'h08, 8'h00, 0, 0, 1, 0, 0, 0)); // 11 add T1, Run dropped
    addv(0, 1, ADD_R3_R1, 0, e(2, 0, 8'h02, 8'h00, 0, 0, 0, 1, 0, 0)); // 12 add T2
    addv(0, 1, ADD_R3_R1, 0, e(3, 0, 8'h00, 8'h08, 0, 1, 0, 0, 0, 1)); // 13 add T3
    addv(0, 1, MV_R3_R3,  0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 14 mv R3,R3 T0
    addv(0, 0, MV_R3_R3,  0, e(1, 0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1)); // 15 mv R3,R3 T1
    addv(0, 1, ADD_R2_R2, 0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 16 add R2,R2 T0
    addv(0, 0, ADD_R2_R2, 0, e(1, 0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 0)); // 17
    addv(0, 0, ADD_R2_R2, 0, e(2, 0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 0)); // 18
    addv(0, 0, ADD_R2_R2, 0, e(3, 0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 1)); // 19
    addv(0, 1, NOP_111,   0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 20 nop T0
    addv(0, 0, NOP_111,   0, e(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)); // 21 nop T1
    addv(0, 1, MVNZ,      0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 22 op100 T0
    addv(0, 0, MVNZ,      0, e(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)); // 23 op100 Gnz=0
    addv(0, 1, MVNZ,      1, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 24 op100 T0
`ifdef MVNZ_EN
    addv(0, 0, MVNZ,      1, e(1, 0, 8'h20, 8'h10, 0, 0, 0, 0, 0, 1)); // 25 mvnz Gnz=1
`else
    addv(0, 0, MVNZ,      1, e(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)); // 25 nop Gnz=1
`endif
    addv(0, 1, ADD_R1_R2, 0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 26 add T0
    addv(0, 0, ADD_R1_R2, 0, e(1, 0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 0)); // 27 add T1
    addv(1, 0, ADD_R1_R2, 0, e(2, 0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 0)); // 28 reset in T2
    addv(0, 0, ADD_R1_R2, 0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 29 aborted, no Rin
    addv(1, 1, MVI_R0,    0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 30 reset+Run in T0
    addv(0, 0, MVI_R0,    0, e(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // 31 reset beat Run

    repeat (2) @(posedge Clock);
    started = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clock);
      Resetn  = vecs[i].rst;
      bus.Run = vecs[i].run;
      bus.IR  = vecs[i].ir;
      bus.Gnz = vecs[i].gnz;
      #1;
      checks++;
      if (actual() !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h required %h", i, actual(), vecs[i].exp);
      end
    end

    // Latency: add from T0 must raise Done on the third edge, then return to T0.
    @(negedge Clock);
    Resetn  = 1'b0;
    bus.Run = 1'b1;
    bus.IR  = ADD_R1_R1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clock);
      bus.Run = 1'b0;
      #1;
      if (bus.Done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL add_latency: got %0d edges to Done, required 3 (-1 = timeout)", lat);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (bus.Done !== 1'b0 || bus.Tstep !== 2'd0 || bus.IRin !== 1'b1) begin
      errors++;
      $display("FAIL done_single_cycle: got Done=%b Tstep=%0d IRin=%b, required Done=0 Tstep=0 IRin=1",
               bus.Done, bus.Tstep, bus.IRin);
    end

    started = 1'b0;
    @(negedge Clock);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Control FSM for the 9-bit simple processor. Sits directly downstream of the instruction register and consumes its 9-bit output `IR = III XXX YYY`.
- Drives the IR load enable, the bus multiplexer selects, the register-file/A/G enables and the ALU mode.
- Sequences each instruction over timesteps T0..T3 and pulses Done on the final step.

Parameters:
- IR_W, 9, instruction width; layout fixed as opcode[8:6], X[5:3], Y[2:0].
- NREG, 8, number of general registers R0..R7; width of the one-hot Rin/Rout vectors.

Ports:
- Clock  input  1  processor clock; FSM state updates on posedge.
- Resetn  input  1  synchronous reset, active-high (despite the name); sampled on posedge Clock.
- Run  input  1  start request; sampled only in T0.
- IR  input  IR_W  instruction from the IR register (loaded on negedge during T0).
- Gnz  input  1  1 when register G != 0; used only with MVNZ_EN.
- IRin  output  1  IR load enable.
- Rout  output  NREG  one-hot select of register Rk onto the bus.
- Rin  output  NREG  one-hot write enable of register Rk.
- DINout  output  1  DIN onto the bus.
- Gout  output  1  G onto the bus.
- Ain  output  1  A register load.
- Gin  output  1  G register load.
- AddSub  output  1  ALU mode: 0 = add, 1 = sub.
- Done  output  1  final step of the current instruction.
- Tstep  output  2  current timestep (debug/verification).

Behaviour:
- State: 2-bit Tstep register with values T0=0, T1=1, T2=2, T3=3.
- Reset: Resetn=1 at posedge forces Tstep=T0 on that edge. This holds from any state (reset mid-instruction aborts it, no Rin is issued after the edge). Resetn has priority over Run.
- Outputs are combinational from (Tstep, IR, Gnz). In T0 after reset: IRin=1, all other outputs 0.
- Transitions:
  - T0 -> T1 if Run=1, else stay T0.
  - T1 -> T0 if Done, else T2.
  - T2 -> T3.
  - T3 -> T0.
- Run is ignored in T1..T3; an instruction always completes.
- Opcode decode, with X/Y as 3-bit indices mapped to one-hot (index k sets bit k):
  - 000 mv Rx,Ry: T1: Rout[Y], Rin[X], Done.
  - 001 mvi Rx,#D: T1: DINout, Rin[X], Done. The immediate is on DIN during T1.
  - 010 add Rx,Ry: T1: Rout[X], Ain. T2: Rout[Y], Gin, AddSub=0. T3: Gout, Rin[X], Done.
  - 011 sub Rx,Ry: same as add, with AddSub=1 in T2.
  - 100..111: NOP. T1: Done only, no enables.
- Latency: mv/mvi/NOP take 2 cycles (T0,T1); add/sub take 4 cycles.
- Back-to-back issue: Done in step Tn is followed by T0 on the next edge. A new instruction starts one cycle later if Run=1.
- X==Y is legal:
  - mv R3,R3: Rout[3]=Rin[3]=1 in T1.
  - add R2,R2: doubles R2.
- At most one of {any Rout bit, DINout, Gout} is 1 in any cycle (single bus driver). Rin is at most one-hot.
- AddSub=0 in every step except T2 of sub.
- Done is high for exactly one cycle per instruction.

Optional Feature:
- Macro: MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry. T1: if Gnz=1 assert Rout[Y], Rin[X], Done; if Gnz=0 assert Done only. Latency is 2 cycles either way.
- Undefined: opcode 100 is a NOP and Gnz is ignored.

Test Plan:
- Reset: Resetn=1 for 2 cycles, Run=0 -> Tstep=0, IRin=1, Done=0, Rin=Rout=0.
- mvi R0,#5: IR=9'b001_000_000, Run=1 -> T1 has DINout=1, Rin=8'h01, Done=1; next cycle Tstep=0.
- mv R1,R0: IR=9'b000_001_000 -> T1 has Rout=8'h01, Rin=8'h02, Done=1.
- sub R2,R3: IR=9'b011_010_011 -> T1 Rout=8'h04, Ain=1; T2 Rout=8'h08, Gin=1, AddSub=1; T3 Gout=1, Rin=8'h04, Done=1.
- Reset mid-op: add started, Resetn=1 during T2 -> Tstep=0 next cycle, no Rin asserted. Run dropped during T1 of add -> still reaches T3 and Done.
- MVNZ_EN: IR=9'b100_100_101 with Gnz=0 -> T1 Done=1, Rin=0. With Gnz=1 -> Rout=8'h20, Rin=8'h10. Macro undefined -> Done only in both cases.
